// File: rtl/occ_rx_pattern_checker_if.sv
// occ_rx_pattern_checker_if: transceiver RX word stream (data, K flags, code error flags, reset done)
// master drives the stream (tile / bench), slave consumes it (checker).
interface occ_rx_pattern_checker_if;
    logic        rxresetdone;
    logic [15:0] rxdata;
    logic [1:0]  rxcharisk;
    logic [1:0]  rxdisperr;
    logic [1:0]  rxnotintable;
    modport master (output rxresetdone, rxdata, rxcharisk, rxdisperr, rxnotintable);
    modport slave  (input  rxresetdone, rxdata, rxcharisk, rxdisperr, rxnotintable);
endinterface

// File: rtl/occ_rx_pattern_checker.sv
// occ_rx_pattern_checker: locks onto the framed counter test stream and counts good/bad/code-error words
// Ports: clk_i/rst_n_i usrclk and async active-low reset; rx RX word stream (slave);
// clear_i sync clear of all counters; locked_o lock status; good/err/code_err/lock_loss
// saturating statistics counters.
module occ_rx_pattern_checker #(
    parameter int          G_PERIOD_LOG2 = 5,
    parameter logic [15:0] G_COMMA       = 16'hBC95,
    parameter int          G_LOSS_ERRORS = 4,
    parameter int          G_CNT_WIDTH   = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    occ_rx_pattern_checker_if.slave      rx,
    input  logic                         clear_i,
    output logic                         locked_o,
    output logic [G_CNT_WIDTH-1:0]       good_cnt_o,
    output logic [G_CNT_WIDTH-1:0]       err_cnt_o,
    output logic [G_CNT_WIDTH-1:0]       code_err_cnt_o,
    output logic [G_CNT_WIDTH-1:0]       lock_loss_cnt_o
);
    typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;
    typedef logic [G_CNT_WIDTH-1:0] cnt_t;
    state_t      state, state_nx;
    logic [15:0] expected, expected_nx;
    logic [3:0]  bad_run, bad_run_nx;
    logic        comma, data, cerr, word_ok, inc_good, inc_err, inc_loss, inc_cerr;
    assign comma    = rx.rxcharisk == 2'b10 && rx.rxdata == G_COMMA;
    assign data     = rx.rxcharisk == 2'b00;
    assign cerr     = |(rx.rxdisperr | rx.rxnotintable);
    // Counter values with zero low bits occupy the comma slot instead of appearing as data.
    assign word_ok  = !cerr && (expected[G_PERIOD_LOG2-1:0] == '0 ? comma : data && rx.rxdata == expected);
    assign inc_cerr = rx.rxresetdone && cerr;
    assign locked_o = state == LOCKED;
    always_comb begin
        state_nx    = state;
        expected_nx = expected;
        bad_run_nx  = bad_run;
        inc_good    = 1'b0;
        inc_err     = 1'b0;
        inc_loss    = 1'b0;
        if (!rx.rxresetdone) begin
            state_nx = SEARCH;
        end else begin
            case (state)
                SEARCH: state_nx = comma ? SYNC : SEARCH;
                SYNC: begin
                    // Only the word right after a comma (counter low bits == 1) can confirm alignment;
                    // a byte-swapped stream never presents that.
                    if (data && rx.rxdata[G_PERIOD_LOG2-1:0] == G_PERIOD_LOG2'(1)) begin
                        state_nx    = LOCKED;
                        expected_nx = rx.rxdata + 16'd1;
                        bad_run_nx  = '0;
                    end else begin
                        state_nx = SEARCH;
                    end
                end
                LOCKED: begin
                    expected_nx = expected + 16'd1;
                    inc_good    = word_ok;
                    inc_err     = !word_ok;
                    if (word_ok) begin
                        bad_run_nx = '0;
                    end else if (bad_run == 4'(G_LOSS_ERRORS - 1)) begin
                        state_nx   = SEARCH;
                        inc_loss   = 1'b1;
                        bad_run_nx = '0;
                    end else begin
                        bad_run_nx = bad_run + 4'd1;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end
    // clear has priority over a same-cycle increment; counters stick at all-ones.
    function automatic cnt_t bump(input cnt_t c, input logic inc, input logic clr);
        return clr ? '0 : (inc && c != '1) ? c + cnt_t'(1) : c;
    endfunction
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= SEARCH;
            expected        <= '0;
            bad_run         <= '0;
            good_cnt_o      <= '0;
            err_cnt_o       <= '0;
            code_err_cnt_o  <= '0;
            lock_loss_cnt_o <= '0;
        end else begin
            state           <= state_nx;
            expected        <= expected_nx;
            bad_run         <= bad_run_nx;
            good_cnt_o      <= bump(good_cnt_o, inc_good, clear_i);
            err_cnt_o       <= bump(err_cnt_o, inc_err, clear_i);
            code_err_cnt_o  <= bump(code_err_cnt_o, inc_cerr, clear_i);
            lock_loss_cnt_o <= bump(lock_loss_cnt_o, inc_loss, clear_i);
        end
    end
endmodule
